mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4:1 4-bit data mux. Four requesters (a, b, c, d) compete for the mux output z. The block owns `sel`, issues one-hot grants, and caps each grant at HOLD beats. It registers the selected data so downstream logic sees one beat per cycle with a valid strobe.

---
 rtl/mux_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 data mux, with a per-grant beat cap of HOLD.
// Optional build macro MUX_ARB_ZERO_EN: z reads 0 in every cycle where valid=0.
module mux_rr_arbiter #(
  parameter int W    = 4,
  parameter int HOLD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] z,
  output logic         valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] last;
  logic [3:0] cnt;

  logic [W-1:0] data_s;
  logic         beat;
  logic         rel;
  logic         idle_found, rel_found;
  logic [1:0]   idle_idx, rel_idx;

  // Returns {found, index} of the first set bit of mask, searching from+1, from+2, ... modulo 4.
  function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] from);
    logic [1:0] idx;
    pick = 3'b000;
    // Walk offsets 4 down to 1 so the nearest requester is assigned last and wins.
    for (int i = 3; i >= 0; i--) begin
      idx = from + 2'(i + 1);
      if (mask[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    data_s = a;
    unique case (sel)
      2'd0: data_s = a;
      2'd1: data_s = b;
      2'd2: data_s = c;
      2'd3: data_s = d;
      default: data_s = a;
    endcase
  end

  assign beat = (state == GRANT) && req[sel] && !en;
  assign rel  = (state == GRANT) && (!req[sel] || (beat && cnt == 4'(HOLD - 1)));

  assign {idle_found, idle_idx} = pick(req, last);
  // On release the current holder is masked out, and its index is the new rotation origin.
  assign {rel_found, rel_idx}   = pick(req & ~gnt, sel);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      z     <= '0;
      valid <= 1'b0;
      cnt   <= 4'd0;
      last  <= 2'b11;
    end else if (en) begin
      if (state == GRANT) last <= sel;
      state <= IDLE;
      gnt   <= 4'b0000;
      z     <= '0;
      valid <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
`ifdef MUX_ARB_ZERO_EN
          z <= '0;
`endif
          if (idle_found) begin
            gnt   <= 4'b0001 << idle_idx;
            sel   <= idle_idx;
            cnt   <= 4'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (beat) begin
            z     <= data_s;
            valid <= 1'b1;
            cnt   <= cnt + 4'd1;
          end else begin
            valid <= 1'b0;
`ifdef MUX_ARB_ZERO_EN
            z <= '0;
`endif
          end
          if (rel) begin
            last <= sel;
            cnt  <= 4'd0;
            if (rel_found) begin
              gnt <= 4'b0001 << rel_idx;
              sel <= rel_idx;
            end else begin
              gnt   <= 4'b0000;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: stimulus pushes expected beats to a queue, a monitor pops them on valid.
module tb_mux_rr_arbiter;
  localparam int W    = 4;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] z;
  logic         valid;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  mux_rr_arbiter #(.W(W), .HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .sel(sel), .z(z), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented beat must match the oldest expected beat.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL z_unexpected: got beat %0h expected none at %0t", z, $time);
        end else begin
          e = exp_q.pop_front();
          check("z_beat", z, e);
        end
      end
    end
  end

  initial begin
    logic [3:0]   e_gnt;
    logic [1:0]   e_sel;
    logic [W-1:0] e_idle_z;

    // Reset with everyone requesting.
    reset = 1'b1; req = 4'b1111; a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
    step();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_sel", sel, 2'b00);
    check("rst_z", z, 0);
    check("rst_valid", valid, 0);
    reset = 1'b0;

    // Continuous rotation: 4 beats each of a, b, c, d, then a again, valid never gaps.
    for (int k = 2; k <= 21; k++) exp_q.push_back(W'(((k - 2) / 4) % 4 + 1));
    for (int k = 1; k <= 21; k++) begin
      step();
      e_sel = 2'(((k - 1) / 4) % 4);
      e_gnt = 4'b0001 << e_sel;
      check("rot_gnt", gnt, e_gnt);
      check("rot_sel", sel, e_sel);
      check("rot_valid", valid, (k >= 2) ? 1 : 0);
    end
    req = 4'b0000;
    step();
    check("drop_all_gnt", gnt, 4'b0000);
    check("drop_all_valid", valid, 0);

    // c alone, drops after two beats; pointer then passes c so a wins over a|c.
    req = 4'b0100; exp_q.push_back(4'd3); exp_q.push_back(4'd3);
    step();
    check("c_gnt", gnt, 4'b0100);
    check("c_sel", sel, 2'd2);
    step(); step();
    req = 4'b0000;
    step();
    check("c_drop_gnt", gnt, 4'b0000);
    check("c_drop_valid", valid, 0);
    check("c_drop_sel_hold", sel, 2'd2);
    req = 4'b0101; exp_q.push_back(4'd1);
    step();
    check("ptr_gnt_a", gnt, 4'b0001);
    check("ptr_sel_a", sel, 2'd0);

    // en=1 mid-grant forces idle with z=0; then d alone is granted.
    step();
    en = 1'b1;
    step();
    check("en_gnt", gnt, 4'b0000);
    check("en_z", z, 0);
    check("en_valid", valid, 0);
    en = 1'b0; req = 4'b1000; exp_q.push_back(4'd4);
    step();
    check("d_gnt", gnt, 4'b1000);
    check("d_sel", sel, 2'd3);
    step();
    req = 4'b0000;
    step();

    // Reset during b's second beat discards it; a is granted first afterwards.
    req = 4'b0010; exp_q.push_back(4'd2);
    step();
    check("b_gnt", gnt, 4'b0010);
    step();
    reset = 1'b1;
    step();
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_sel", sel, 2'b00);
    check("midrst_z", z, 0);
    check("midrst_valid", valid, 0);
    reset = 1'b0; req = 4'b0001;
    step();
    check("postrst_gnt", gnt, 4'b0001);
    req = 4'b0000;
    step();

    // a alone keeps requesting: HOLD beats, released to idle, then regranted.
    a = 4'd5; req = 4'b0001;
    for (int i = 0; i < HOLD; i++) exp_q.push_back(4'd5);
    step();
    check("hold_gnt", gnt, 4'b0001);
    repeat (HOLD) step();
    check("hold_rel_gnt", gnt, 4'b0000);
    step();
    check("regrant_gnt", gnt, 4'b0001);
    check("regrant_valid", valid, 0);

    // Final beat of 9, then idle: z reads 0 or keeps 9 depending on build.
    a = 4'd9; exp_q.push_back(4'd9);
    step();
    req = 4'b0000;
`ifdef MUX_ARB_ZERO_EN
    e_idle_z = '0;
`else
    e_idle_z = 4'd9;
`endif
    step();
    check("idle_z", z, e_idle_z);
    check("idle_valid", valid, 0);
    step();
    check("idle_z_hold", z, e_idle_z);
    check("idle_gnt", gnt, 4'b0000);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
